// File: rtl/rvx_spi_subordinate.sv
// SPI mode-0 subordinate with an RVX register interface: one RX byte buffer, one TX holding byte.
// Optional RX interrupt (CONTROL bit1 and the spi_irq port) built when RVX_SPI_SUBORDINATE_IRQ_EN is defined.
module rvx_spi_subordinate (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  rw_address,
   output logic [31:0] read_data,
   input  logic        read_request,
   output logic        read_response,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_strobe,
   input  logic        write_request,
   output logic        write_response,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        cs,
   output logic        miso
`ifdef RVX_SPI_SUBORDINATE_IRQ_EN
   ,
   output logic        spi_irq
`endif
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [2:0] REG_TXDATA  = 3'd0;
   localparam logic [2:0] REG_RXDATA  = 3'd1;
   localparam logic [2:0] REG_STATUS  = 3'd2;
   localparam logic [2:0] REG_CONTROL = 3'd3;

   state_t     state_q, state_d;
   logic [1:0] sclk_sync, mosi_sync, cs_sync;
   logic       sclk_prev, cs_prev;
   logic       sclk_s, mosi_s, cs_s;
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic       start_frame, end_frame, shift_in, shift_out;
   logic       tx_load, byte_done;
   logic [7:0] rx_byte;

   logic [2:0] bit_count;
   logic [7:0] rx_shift, tx_shift, rx_data, tx_hold;
   logic       rx_valid, tx_full, overrun, enable, busy;
   logic       rx_irq_en_bit;
   logic [31:0] rd_value;
   logic       wr_en, wr_tx, wr_status, wr_control, rd_rx;
   logic       unused_bits;

   assign unused_bits = ^{write_data[31:8], write_strobe[3:1], rw_address[1:0]};

   // The cs synchronizer resets low so a frame already in progress at reset
   // release produces no falling edge and is ignored until cs cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a true shift chain.
         sclk_sync <= {sclk_sync[0], sclk};
         mosi_sync <= {mosi_sync[0], mosi};
         cs_sync   <= {cs_sync[0], cs};
         sclk_prev <= sclk_sync[1];
         cs_prev   <= cs_sync[1];
      end
   end

   assign sclk_s    = sclk_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign cs_s      = cs_sync[1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_fall   = ~cs_s & cs_prev;
   assign cs_rise   = cs_s & ~cs_prev;
   assign busy      = ~cs_s & enable;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
      state_d     = state_q;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      shift_in    = 1'b0;
      shift_out   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall && enable) begin
               state_d     = ACTIVE;
               start_frame = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise || !enable) begin
               state_d   = IDLE;
               end_frame = 1'b1;
            end else begin
               shift_in  = sclk_rise;
               shift_out = sclk_fall;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_load   = start_frame | (shift_out && bit_count == 3'd0);
   assign byte_done = shift_in && bit_count == 3'd7;
   assign rx_byte   = {rx_shift[6:0], mosi_s};
   assign miso      = (state_q == ACTIVE) & tx_shift[7];

   assign wr_en      = write_request & write_strobe[0];
   assign wr_tx      = wr_en && rw_address[4:2] == REG_TXDATA;
   assign wr_status  = wr_en && rw_address[4:2] == REG_STATUS;
   assign wr_control = wr_en && rw_address[4:2] == REG_CONTROL;
   assign rd_rx      = read_request && rw_address[4:2] == REG_RXDATA;

   // Later assignments in this block win: a bus write overrides a same-cycle
   // load clearing tx_full, and a byte completion overrides an RX read clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_count <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         rx_data   <= '0;
         tx_hold   <= '0;
         rx_valid  <= 1'b0;
         tx_full   <= 1'b0;
         overrun   <= 1'b0;
         enable    <= 1'b0;
      end else begin
         if (start_frame || end_frame) bit_count <= '0;
         else if (shift_in)            bit_count <= bit_count + 3'd1;

         if (shift_in) rx_shift <= rx_byte;

         if (tx_load)        tx_shift <= tx_full ? tx_hold : 8'hFF;
         else if (shift_out) tx_shift <= {tx_shift[6:0], 1'b0};

         if (tx_load) tx_full <= 1'b0;
         if (wr_tx) begin
            tx_hold <= write_data[7:0];
            tx_full <= 1'b1;
         end

         if (rd_rx) rx_valid <= 1'b0;
         if (wr_status && write_data[2]) overrun <= 1'b0;
         if (byte_done) begin
            if (!rx_valid || rd_rx) begin
               rx_data  <= rx_byte;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end

         if (wr_control) enable <= write_data[0];
      end
   end

`ifdef RVX_SPI_SUBORDINATE_IRQ_EN
   logic rx_irq_en;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_irq_en <= 1'b0;
         spi_irq   <= 1'b0;
      end else begin
         if (wr_control) rx_irq_en <= write_data[1];
         spi_irq <= rx_irq_en & (rx_valid | overrun);
      end
   end

   assign rx_irq_en_bit = rx_irq_en;
`else
   assign rx_irq_en_bit = 1'b0;
`endif

   always_comb begin
      rd_value = '0;
      case (rw_address[4:2])
         REG_TXDATA:  rd_value = {24'd0, tx_hold};
         REG_RXDATA:  rd_value = {24'd0, rx_data};
         REG_STATUS:  rd_value = {28'd0, busy, overrun, tx_full, rx_valid};
         REG_CONTROL: rd_value = {30'd0, rx_irq_en_bit, enable};
         default:     rd_value = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         read_data      <= '0;
         read_response  <= 1'b0;
         write_response <= 1'b0;
      end else begin
         read_data      <= read_request ? rd_value : 32'd0;
         read_response  <= read_request;
         write_response <= write_request;
      end
   end

endmodule

// File: tb/tb_rvx_spi_subordinate.sv
// Directed bench for rvx_spi_subordinate: acts as SPI mode-0 manager and bus host.
// Expected values are hand-computed from the register map and frame rules.
module tb_rvx_spi_subordinate;

   localparam int HALF = 8;   // sclk half period in clock cycles

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rw_address = '0;
   logic [31:0] read_data;
   logic        read_request = 1'b0;
   logic        read_response;
   logic [31:0] write_data = '0;
   logic [3:0]  write_strobe = '0;
   logic        write_request = 1'b0;
   logic        write_response;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic        cs = 1'b1;
   logic        miso;
`ifdef RVX_SPI_SUBORDINATE_IRQ_EN
   logic        spi_irq;
`endif

   int compared   = 0;
   int mismatched = 0;
   logic [7:0] m1, m2;

   rvx_spi_subordinate dut (
      .clock          (clock),
      .reset          (reset),
      .rw_address     (rw_address),
      .read_data      (read_data),
      .read_request   (read_request),
      .read_response  (read_response),
      .write_data     (write_data),
      .write_strobe   (write_strobe),
      .write_request  (write_request),
      .write_response (write_response),
      .sclk           (sclk),
      .mosi           (mosi),
      .cs             (cs),
      .miso           (miso)
`ifdef RVX_SPI_SUBORDINATE_IRQ_EN
      ,
      .spi_irq        (spi_irq)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic bus_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
      @(negedge clock);
      rw_address    = addr;
      write_data    = data;
      write_strobe  = strb;
      write_request = 1'b1;
      @(negedge clock);
      write_request = 1'b0;
      check("write_response", {31'd0, write_response}, 32'd1);
   endtask

   task automatic bus_read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      @(negedge clock);
      rw_address   = addr;
      read_request = 1'b1;
      @(negedge clock);
      read_request = 1'b0;
      check({tag, "_rsp"}, {31'd0, read_response}, 32'd1);
      check(tag, read_data, exp);
   endtask

   task automatic cs_assert();
      @(negedge clock);
      cs = 1'b0;
      wait_cycles(HALF);
   endtask

   task automatic cs_deassert();
      cs = 1'b1;
      wait_cycles(HALF);
   endtask

   // Shifts out the top nbits of d MSB first; m collects miso sampled before each rising sclk.
   task automatic spi_xfer(input logic [7:0] d, input int nbits, output logic [7:0] m);
      m = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = d[7-i];
         wait_cycles(HALF);
         m = {m[6:0], miso};
         sclk = 1'b1;
         wait_cycles(HALF);
         sclk = 1'b0;
      end
      wait_cycles(HALF);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wait_cycles(3);
      reset = 1'b0;
      wait_cycles(2);
   endtask

   initial begin
      do_reset();

      // Reset state
      check("reset_miso", {31'd0, miso}, 32'd0);
      check("reset_read_data", read_data, 32'd0);
      bus_read_check("reset_tx", 5'h00, 32'h0);
      bus_read_check("reset_rx", 5'h04, 32'h0);
      bus_read_check("reset_status", 5'h08, 32'h0);
      bus_read_check("reset_control", 5'h0C, 32'h0);
      bus_read_check("unmapped", 5'h10, 32'h0);
      @(negedge clock);
      check("read_data_idle", read_data, 32'd0);

      // Basic exchange: TX 0xA5 out, 0x3C in
      bus_write(5'h0C, 32'h1, 4'hF);
      bus_read_check("control_en", 5'h0C, 32'h1);
      bus_write(5'h00, 32'hA5, 4'hF);
      bus_read_check("status_txfull", 5'h08, 32'h2);
      cs_assert();
      bus_read_check("status_busy", 5'h08, 32'h8);
      spi_xfer(8'h3C, 8, m1);
      cs_deassert();
      check("basic_miso", {24'd0, m1}, 32'hA5);
      bus_read_check("basic_status", 5'h08, 32'h1);
      bus_read_check("basic_rx", 5'h04, 32'h3C);
      bus_read_check("basic_status_clr", 5'h08, 32'h0);

      // Two-byte frame with empty TX, RX read between bytes
      cs_assert();
      spi_xfer(8'h11, 8, m1);
      bus_read_check("two_rx1", 5'h04, 32'h11);
      spi_xfer(8'h22, 8, m2);
      cs_deassert();
      check("two_miso1", {24'd0, m1}, 32'hFF);
      check("two_miso2", {24'd0, m2}, 32'hFF);
      bus_read_check("two_rx2", 5'h04, 32'h22);

      // Overrun: second byte dropped
      cs_assert(); spi_xfer(8'h55, 8, m1); cs_deassert();
      cs_assert(); spi_xfer(8'h66, 8, m1); cs_deassert();
      bus_read_check("ovr_status", 5'h08, 32'h5);
      bus_read_check("ovr_rx", 5'h04, 32'h55);
      bus_read_check("ovr_status2", 5'h08, 32'h4);
      bus_write(5'h08, 32'h4, 4'hF);
      bus_read_check("ovr_cleared", 5'h08, 32'h0);

      // Abort after 5 bits, then a full frame
      cs_assert(); spi_xfer(8'hF8, 5, m1); cs_deassert();
      bus_read_check("abort_status", 5'h08, 32'h0);
      cs_assert(); spi_xfer(8'h81, 8, m1); cs_deassert();
      bus_read_check("abort_rx", 5'h04, 32'h81);

      // TX overwrite and strobe-lane gating
      bus_write(5'h00, 32'h12, 4'hF);
      bus_write(5'h00, 32'h34, 4'hF);
      bus_write(5'h00, 32'h99, 4'hE);
      bus_read_check("tx_hold", 5'h00, 32'h34);
      cs_assert(); spi_xfer(8'h00, 8, m1); cs_deassert();
      check("tx_overwrite_miso", {24'd0, m1}, 32'h34);
      bus_read_check("tx_rx_zero", 5'h04, 32'h00);

      // Disabled block ignores frames and keeps miso low
      bus_write(5'h0C, 32'h0, 4'hF);
      cs_assert(); spi_xfer(8'h42, 8, m1); cs_deassert();
      check("disabled_miso", {24'd0, m1}, 32'h00);
      bus_read_check("disabled_status", 5'h08, 32'h0);

`ifdef RVX_SPI_SUBORDINATE_IRQ_EN
      bus_write(5'h0C, 32'h3, 4'hF);
      bus_read_check("irq_control", 5'h0C, 32'h3);
      cs_assert(); spi_xfer(8'h01, 8, m1); cs_deassert();
      check("irq_set", {31'd0, spi_irq}, 32'd1);
      bus_read_check("irq_rx", 5'h04, 32'h01);
      @(negedge clock);
      check("irq_clear", {31'd0, spi_irq}, 32'd0);
`else
      bus_write(5'h0C, 32'h3, 4'hF);
      bus_read_check("control_no_irq", 5'h0C, 32'h1);
`endif

      // Reset mid-frame: remainder of the frame must be ignored
      cs_assert();
      spi_xfer(8'hE0, 3, m1);
      do_reset();
      bus_read_check("midreset_control", 5'h0C, 32'h0);
      bus_write(5'h0C, 32'h1, 4'hF);
      bus_read_check("midreset_busy", 5'h08, 32'h8);
      spi_xfer(8'hA8, 5, m1);
      check("midreset_miso", {24'd0, m1}, 32'h00);
      cs_deassert();
      bus_read_check("midreset_status", 5'h08, 32'h0);
      bus_read_check("midreset_rx", 5'h04, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
